// File: rtl/clock_rate_controller.sv
// Programmable clock divider with glitch-free runtime divisor changes.
// Divisor swaps and stops land only on falling edges of clk_out.
module clock_rate_controller #(
   parameter int DIV_WIDTH   = 8,
   parameter int DEFAULT_DIV = 8
) (
   input  logic                 clk_in,
   input  logic                 reset,
   input  logic                 enable,
   input  logic                 cfg_valid,
   input  logic [DIV_WIDTH-1:0] cfg_div,
   output logic                 cfg_ready,
   output logic                 clk_out,
   output logic                 tick,
   output logic                 running,
   output logic [DIV_WIDTH-1:0] cur_div
);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      PENDING,
      STOPPING
   } state_t;

   localparam logic [DIV_WIDTH-1:0] ONE = DIV_WIDTH'(1);
   localparam logic [DIV_WIDTH-1:0] DEF_EFF =
      (DEFAULT_DIV == 0) ? ONE : DIV_WIDTH'(DEFAULT_DIV);

   state_t               state;
   state_t               state_nxt;
   logic [DIV_WIDTH-1:0] cnt;
   logic [DIV_WIDTH-1:0] pend_div;
   logic                 pend_vld;
   logic [DIV_WIDTH-1:0] cfg_eff;
   logic                 accept;
   logic                 tc;
   logic                 fall_tc;
   logic                 stop_hold;

   // A zero divisor behaves as one; terminal count only while active
   always_comb begin
      cfg_eff   = (cfg_div == '0) ? ONE : cfg_div;
      accept    = cfg_valid && cfg_ready;
      tc        = (state != IDLE) && (cnt == cur_div - ONE);
      fall_tc   = tc && clk_out;
      stop_hold = clk_out && !tc;
   end

   // State register
   always_ff @(posedge clk_in) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next-state logic: stops wait for the high phase to finish
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (enable) state_nxt = RUN;
         end
         RUN: begin
            if (!enable)
               state_nxt = stop_hold ? STOPPING : IDLE;
            else if (accept)
               state_nxt = PENDING;
         end
         PENDING: begin
            if (!enable)
               state_nxt = stop_hold ? STOPPING : IDLE;
            else if (fall_tc)
               state_nxt = RUN;
         end
         STOPPING: begin
            if (fall_tc) state_nxt = IDLE;
         end
      endcase
   end

   // Moore outputs decoded from the state
   always_comb begin
      cfg_ready = (state == IDLE) || (state == RUN);
      running   = (state != IDLE);
   end

   // Counter, divided clock, tick and divisor registers
   always_ff @(posedge clk_in) begin
      if (reset) begin
         cnt      <= '0;
         clk_out  <= 1'b0;
         tick     <= 1'b0;
         cur_div  <= DEF_EFF;
         pend_div <= '0;
         pend_vld <= 1'b0;
      end else if (state_nxt == IDLE) begin
         cnt      <= '0;
         clk_out  <= 1'b0;
         tick     <= clk_out;
         pend_vld <= 1'b0;
         if (accept)
            cur_div <= cfg_eff;
         else if (pend_vld)
            cur_div <= pend_div;
      end else begin
         tick <= 1'b0;
         if (state == IDLE) begin
            cnt <= '0;
         end else if (tc) begin
            cnt     <= '0;
            clk_out <= ~clk_out;
            tick    <= 1'b1;
         end else begin
            cnt <= cnt + ONE;
         end
         if (state == PENDING && state_nxt == RUN) begin
            cur_div  <= pend_div;
            pend_vld <= 1'b0;
         end
         if (accept && state == IDLE) begin
            cur_div <= cfg_eff;
         end else if (accept) begin
            pend_div <= cfg_eff;
            pend_vld <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_clock_rate_controller.sv
// Directed self-checking bench for clock_rate_controller.
// Expected values are hand-derived edge counts from RUN entry.
module tb_clock_rate_controller;

   logic       clk_in;
   logic       reset;
   logic       enable;
   logic       cfg_valid;
   logic [7:0] cfg_div;
   logic       cfg_ready;
   logic       clk_out;
   logic       tick;
   logic       running;
   logic [7:0] cur_div;

   int checks = 0;
   int errors = 0;

   clock_rate_controller #(
      .DIV_WIDTH  (8),
      .DEFAULT_DIV(8)
   ) dut (
      .clk_in   (clk_in),
      .reset    (reset),
      .enable   (enable),
      .cfg_valid(cfg_valid),
      .cfg_div  (cfg_div),
      .cfg_ready(cfg_ready),
      .clk_out  (clk_out),
      .tick     (tick),
      .running  (running),
      .cur_div  (cur_div)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   task automatic steps(input int n);
      repeat (n) step();
   endtask

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      assert (got === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      reset     = 1'b1;
      enable    = 1'b0;
      cfg_valid = 1'b0;
      cfg_div   = 8'd0;
      steps(2);
      check("rst_clk", clk_out, 0);
      check("rst_tick", tick, 0);
      check("rst_running", running, 0);
      check("rst_ready", cfg_ready, 1);
      check("rst_div", cur_div, 8);

      // default divisor 8: rise 8 edges after RUN entry
      reset  = 1'b0;
      enable = 1'b1;
      step();
      check("d8_run", running, 1);
      check("d8_entry_clk", clk_out, 0);
      steps(7);
      check("d8_pre_rise", clk_out, 0);
      step();
      check("d8_rise", clk_out, 1);
      check("d8_rise_tick", tick, 1);
      steps(7);
      check("d8_pre_fall", clk_out, 1);
      check("d8_hi_tick", tick, 0);
      step();
      check("d8_fall", clk_out, 0);
      check("d8_fall_tick", tick, 1);
      n = 0;
      repeat (32) begin
         step();
         n += int'(tick);
      end
      check("d8_tick_count", n, 4);
      check("d8_end_clk", clk_out, 0);

      // change to 2 while low: high phase stays 8
      check("pd_ready_before", cfg_ready, 1);
      cfg_valid = 1'b1;
      cfg_div   = 8'd2;
      step();
      cfg_valid = 1'b0;
      check("pd_ready_low", cfg_ready, 0);
      check("pd_div_old", cur_div, 8);
      steps(7);
      check("pd_rise", clk_out, 1);
      check("pd_ready_hi", cfg_ready, 0);
      steps(7);
      check("pd_hi_hold", clk_out, 1);
      step();
      check("pd_fall", clk_out, 0);
      check("pd_fall_tick", tick, 1);
      check("pd_div_new", cur_div, 2);
      check("pd_ready_back", cfg_ready, 1);
      step();
      check("pd2_low", clk_out, 0);
      step();
      check("pd2_rise", clk_out, 1);
      steps(2);
      check("pd2_fall", clk_out, 0);

      // stop while low goes straight to IDLE
      enable = 1'b0;
      step();
      check("stop_low_idle", running, 0);
      check("stop_low_clk", clk_out, 0);

      // divisor 3 loaded in IDLE
      cfg_valid = 1'b1;
      cfg_div   = 8'd3;
      step();
      cfg_valid = 1'b0;
      check("d3_div", cur_div, 3);
      check("d3_idle", running, 0);
      enable = 1'b1;
      step();
      steps(2);
      check("d3_pre_rise", clk_out, 0);
      step();
      check("d3_rise", clk_out, 1);
      steps(2);
      check("d3_pre_fall", clk_out, 1);
      step();
      check("d3_fall", clk_out, 0);
      check("d3_fall_tick", tick, 1);

      // divisor 0 behaves as 1
      enable = 1'b0;
      step();
      cfg_valid = 1'b1;
      cfg_div   = 8'd0;
      step();
      cfg_valid = 1'b0;
      check("d0_div", cur_div, 1);
      enable = 1'b1;
      step();
      check("d0_entry", clk_out, 0);
      step();
      check("d0_hi", clk_out, 1);
      check("d0_hi_tick", tick, 1);
      step();
      check("d0_lo", clk_out, 0);
      check("d0_lo_tick", tick, 1);
      step();
      check("d0_hi2", clk_out, 1);
      enable = 1'b0;
      step();
      check("d0_stop_clk", clk_out, 0);
      check("d0_stop_run", running, 0);

      // stop while high at counter 2, re-enable mid-stop
      cfg_valid = 1'b1;
      cfg_div   = 8'd8;
      step();
      cfg_valid = 1'b0;
      enable    = 1'b1;
      step();
      steps(8);
      check("st_rise", clk_out, 1);
      steps(2);
      enable = 1'b0;
      step();
      check("st_stopping_run", running, 1);
      check("st_stopping_rdy", cfg_ready, 0);
      enable = 1'b1;
      steps(4);
      check("st_hold_hi", clk_out, 1);
      check("st_hold_run", running, 1);
      step();
      check("st_fall", clk_out, 0);
      check("st_fall_tick", tick, 1);
      check("st_idle", running, 0);
      step();
      check("st_rerun", running, 1);
      check("st_rerun_clk", clk_out, 0);

      // reset while PENDING discards the pending divisor
      cfg_valid = 1'b1;
      cfg_div   = 8'd5;
      step();
      cfg_valid = 1'b0;
      check("rp_pending_rdy", cfg_ready, 0);
      step();
      reset = 1'b1;
      step();
      check("rp_clk", clk_out, 0);
      check("rp_div", cur_div, 8);
      check("rp_ready", cfg_ready, 1);
      check("rp_running", running, 0);
      reset = 1'b0;
      step();
      steps(7);
      check("rp_pre_rise", clk_out, 0);
      step();
      check("rp_rise", clk_out, 1);
      steps(8);
      check("rp_fall", clk_out, 0);
      check("rp_div_kept", cur_div, 8);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
